// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bus.
// master (fetch unit): drives req/addr, receives gnt/rvalid/rdata.
// slave (memory): the reverse.
interface fetch_unit_if;
  logic        req;
  logic [29:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  modport master(output req, addr, input gnt, rvalid, rdata);
  modport slave(input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with IF/ID register and one-entry hold buffer.
// Ports: clk, rst (async, active high); i_next_pc/i_redirect/i_stall from core;
// imem (fetch_unit_if.master) to instruction memory; o_cur_pc to next-PC logic;
// o_if_valid/o_if_pc/o_if_instr form the IF/ID register.
module fetch_unit (
  input  logic         clk,
  input  logic         rst,
  input  logic [29:0]  i_next_pc,
  input  logic         i_redirect,
  input  logic         i_stall,
  fetch_unit_if.master imem,
  output logic [29:0]  o_cur_pc,
  output logic         o_if_valid,
  output logic [29:0]  o_if_pc,
  output logic [31:0]  o_if_instr
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;
  state_t      r_state, w_next;
  logic [29:0] r_pc, r_hold_pc, r_if_pc;
  logic [31:0] r_hold_instr, r_if_instr;
  logic        r_if_valid, w_deliver, w_req;
  // An instruction enters IF/ID only when decode accepts and no redirect squashes it.
  assign w_deliver = !i_redirect && !i_stall &&
                     ((r_state == S_WAIT && imem.rvalid) || r_state == S_HOLD);
  always_comb begin
    w_next = r_state;
    w_req  = r_state == S_REQ && !rst;
    case (r_state)
      S_REQ:  w_next = imem.gnt ? (i_redirect ? S_DROP : S_WAIT) : S_REQ;
      S_WAIT: w_next = imem.rvalid ? ((i_stall && !i_redirect) ? S_HOLD : S_REQ)
                                   : (i_redirect ? S_DROP : S_WAIT);
      S_HOLD: w_next = (i_stall && !i_redirect) ? S_HOLD : S_REQ;
      S_DROP: w_next = imem.rvalid ? S_REQ : S_DROP;
      default: w_next = S_REQ;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_REQ;
      r_pc         <= '0;
      r_hold_pc    <= '0;
      r_hold_instr <= '0;
      r_if_valid   <= 1'b0;
      r_if_pc      <= '0;
      r_if_instr   <= '0;
    end else begin
      r_state <= w_next;
      if (i_redirect || w_deliver) r_pc <= i_next_pc;
      // Capturing on every WAIT response is harmless: the buffer is only read in HOLD.
      if (r_state == S_WAIT && imem.rvalid) {r_hold_pc, r_hold_instr} <= {r_pc, imem.rdata};
      if (i_redirect) r_if_valid <= 1'b0;
      else if (!i_stall) r_if_valid <= w_deliver;
      if (w_deliver)
        {r_if_pc, r_if_instr} <= r_state == S_HOLD ? {r_hold_pc, r_hold_instr}
                                                   : {r_pc, imem.rdata};
    end
  end
  assign imem.req   = w_req;
  assign imem.addr  = r_pc;
  assign o_cur_pc   = r_pc;
  assign o_if_valid = r_if_valid;
  assign o_if_pc    = r_if_pc;
  assign o_if_instr = r_if_instr;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a transaction-level model.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [29:0] next_pc = '0;
  logic        redirect = 1'b0, stall = 1'b0;
  logic [29:0] cur_pc, if_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  int          vec = 0, err = 0;
  fetch_unit_if imem();
  fetch_unit dut (
    .clk(clk), .rst(rst), .i_next_pc(next_pc), .i_redirect(redirect), .i_stall(stall),
    .imem(imem), .o_cur_pc(cur_pc), .o_if_valid(if_valid), .o_if_pc(if_pc), .o_if_instr(if_instr)
  );
  always #5 clk = ~clk;
  // Model: one request may be in flight (possibly killed by a redirect); a stalled
  // response waits in a queue; IF/ID is a plain record.
  logic [29:0] m_pc = '0, m_ifpc = '0;
  logic [31:0] m_ifinstr = '0;
  bit          m_valid = 0, m_out = 0, m_kill = 0;
  logic [61:0] m_held[$];
  function automatic logic [31:0] mem(logic [29:0] a);
    return {a, 2'b11} ^ 32'h5A5A_C3C3;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_pc = '0; m_ifpc = '0; m_ifinstr = '0;
    m_valid = 0; m_out = 0; m_kill = 0;
    m_held.delete();
  endtask
  task automatic check_all();
    chk("req", 32'(imem.req), rst ? 32'd0 : 32'(!m_out && m_held.size() == 0));
    chk("addr", 32'(imem.addr), 32'(m_pc));
    chk("cur_pc", 32'(cur_pc), 32'(m_pc));
    chk("if_valid", 32'(if_valid), 32'(m_valid));
    chk("if_pc", 32'(if_pc), 32'(m_ifpc));
    chk("if_instr", if_instr, m_ifinstr);
  endtask
  task automatic model_step(bit g, bit rv, logic [31:0] d, bit s, bit r, logic [29:0] np);
    logic [61:0] arr;
    bit have, req;
    req = !m_out && m_held.size() == 0;
    have = 0;
    arr = '0;
    if (rv && m_out) begin
      m_out = 0;
      if (!m_kill && !r) begin arr = {m_pc, d}; have = 1; end
      m_kill = 0;
    end
    if (r && m_out) m_kill = 1;
    if (req && g) begin m_out = 1; m_kill = r; end
    if (r) begin
      m_held.delete(); m_valid = 0; m_pc = np;
    end else begin
      if (m_held.size() > 0) begin arr = m_held.pop_front(); have = 1; end
      if (have && !s) begin {m_ifpc, m_ifinstr} = arr; m_valid = 1; m_pc = np; end
      else if (have) m_held.push_back(arr);
      else if (!s) m_valid = 0;
    end
  endtask
  // Called just after a falling edge: apply one cycle of inputs, then check after it.
  task automatic drive(bit g, bit rv, logic [31:0] d, bit s, bit r, logic [29:0] tgt);
    logic [29:0] np;
    np = r ? tgt : m_pc + 30'd1;
    imem.gnt = g; imem.rvalid = rv; imem.rdata = d;
    stall = s; redirect = r; next_pc = np;
    model_step(g, rv, d, s, r, np);
    @(negedge clk);
    check_all();
  endtask
  bit          busy = 0, rq, rv, g;
  int          cnt = 0;
  logic [29:0] maddr = '0, a;
  initial begin
    imem.gnt = 0; imem.rvalid = 0; imem.rdata = '0;
    #12;
    chk("rst_req", 32'(imem.req), 32'd0);
    check_all();
    @(negedge clk);
    rst = 0;
    #1 check_all();
    // Basic fetch: grant at once, data one cycle later.
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 32'h2008_0001, 0, 0, 0);
    chk("d1_instr", if_instr, 32'h2008_0001);
    chk("d1_pc", 32'(if_pc), 32'd0);
    chk("d1_cur", 32'(cur_pc), 32'd1);
    chk("d1_req", 32'(imem.req), 32'd1);
    // Response arrives under stall: held, then delivered when stall drops.
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 32'h8C09_0004, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    chk("hold_instr", if_instr, 32'h2008_0001);
    chk("hold_req", 32'(imem.req), 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    chk("d2_instr", if_instr, 32'h8C09_0004);
    chk("d2_cur", 32'(cur_pc), 32'd2);
    // Redirect while waiting: the late response is dropped.
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 30'h100);
    chk("drop_valid", 32'(if_valid), 32'd0);
    drive(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    chk("drop_instr", if_instr, 32'h8C09_0004);
    chk("drop_addr", 32'(imem.addr), 32'h100);
    chk("drop_req", 32'(imem.req), 32'd1);
    // Redirect beats stall with a valid IF/ID.
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 32'h1111_1111, 0, 0, 0);
    chk("rs_pre", 32'(if_valid), 32'd1);
    drive(0, 0, 0, 1, 1, 30'h2AA);
    chk("rs_valid", 32'(if_valid), 32'd0);
    chk("rs_cur", 32'(cur_pc), 32'h2AA);
    // Randomized traffic with a memory of 1..3 cycles latency.
    for (int i = 0; i < 500; i++) begin
      rq = !m_out && m_held.size() == 0;
      a = m_pc;
      rv = busy && cnt == 0;
      g = $urandom_range(0, 3) != 0;
      if (busy && cnt > 0) cnt--;
      drive(g, rv, rv ? mem(maddr) : $urandom, $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0, 30'($urandom));
      if (rv) busy = 0;
      if (rq && g) begin busy = 1; maddr = a; cnt = $urandom_range(0, 2); end
    end
    // Drain any outstanding response before the reset test.
    for (int i = 0; i < 8 && (busy || m_held.size() > 0); i++) begin
      rv = busy && cnt == 0;
      if (busy && cnt > 0) cnt--;
      drive(0, rv, rv ? mem(maddr) : 32'h0, 0, 0, 0);
      if (rv) busy = 0;
    end
    chk("drained", 32'(busy || m_held.size() > 0), 32'd0);
    // Asynchronous reset in WAIT, then a stray response that must be ignored.
    if (!(!m_out && m_held.size() == 0)) drive(0, 0, 0, 0, 1, 30'h3);
    drive(1, 0, 0, 0, 0, 0);
    chk("pre_rst_out", 32'(m_out), 32'd1);
    #2 rst = 1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 0;
    drive(0, 1, 32'hBAD0_BAD0, 0, 0, 0);
    chk("stray_addr", 32'(imem.addr), 32'd0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 32'h0BAD_F00D, 0, 0, 0);
    chk("post_instr", if_instr, 32'h0BAD_F00D);
    chk("post_cur", 32'(cur_pc), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
